// File: rtl/i2s_master_if.sv
// i2s_master_if: groups the I2S pins, PCM words and handshake of i2s_master.
//   master modport : seen from the i2s_master (drives bclk/lrclk/tx, rx_pcm_*, full, ovr)
//   slave modport  : seen from the system / codec side (drives config, rx, tx_pcm_*, push/pop)
//   enable         : 1 = run the link, 0 = idle and clear
//   div[7:0]       : bclk half-period = div+1 clk cycles (captured at enable rise)
//   align[4:0]     : slot of the data MSB within a channel half (captured at enable rise)
//   bclk/lrclk/tx  : bit clock, word select (0 = left), serial data out
//   rx             : serial data in
//   tx_pcm_l/r     : words to send; rx_pcm_l/r : words received
//   full           : frame received and tx words taken; push/pop toggles acknowledge it
//   ovr            : sticky overrun
interface i2s_master_if;
  logic        enable;
  logic [7:0]  div;
  logic [4:0]  align;
  logic        bclk;
  logic        lrclk;
  logic        tx;
  logic        rx;
  logic [15:0] tx_pcm_l;
  logic [15:0] tx_pcm_r;
  logic [15:0] rx_pcm_l;
  logic [15:0] rx_pcm_r;
  logic        full;
  logic        push;
  logic        pop;
  logic        ovr;

  modport master (
    input  enable, div, align, rx, tx_pcm_l, tx_pcm_r, push, pop,
    output bclk, lrclk, tx, rx_pcm_l, rx_pcm_r, full, ovr
  );

  modport slave (
    output enable, div, align, rx, tx_pcm_l, tx_pcm_r, push, pop,
    input  bclk, lrclk, tx, rx_pcm_l, rx_pcm_r, full, ovr
  );
endinterface

// File: rtl/i2s_master.sv
// i2s_master: 16-bit stereo I2S bus master, 64 bclk per frame, 32 slots per channel.
//   clk  : sole clock, all state on the rising edge
//   rstn : asynchronous active-low reset
//   bus  : i2s_master_if.master (pins, PCM words, push/pop handshake, full/ovr)
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | link stopped: bclk/lrclk/tx/cnt/full/ovr held 0; an enable
//           | seen here captures div/align and starts slot 0
//   ST_RUN  | link running: divider counting, slots advancing
module i2s_master (
  input  logic         clk,
  input  logic         rstn,
  i2s_master_if.master bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [4:0]  align_q, align_d;
  logic        bclk_q, bclk_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        tx_q, tx_d;
  logic [15:0] tx_sh_l_q, tx_sh_l_d, tx_sh_r_q, tx_sh_r_d;
  logic [15:0] rx_sh_l_q, rx_sh_l_d, rx_sh_r_q, rx_sh_r_d;
  logic [15:0] rx_pcm_l_q, rx_pcm_l_d, rx_pcm_r_q, rx_pcm_r_d;
  logic        full_q, full_d;
  logic        ovr_q, ovr_d;
  logic        push_q, pop_q;

  logic        clr;
  logic        slot_step;
  logic        slot_start;
  logic [4:0]  win_align;
  logic [4:0]  align_clamp;
  logic [15:0] tx_src_l, tx_src_r;

  // True when slot lies in the 16-slot data window of the left (rgt=0)
  // or right (rgt=1) channel half.
  function automatic logic in_win(input logic [5:0] slot, input logic [4:0] al,
                                  input logic rgt);
    logic [6:0] lo;
    lo = {2'b00, al} + (rgt ? 7'd32 : 7'd0);
    return ({1'b0, slot} >= lo) && ({1'b0, slot} <= lo + 7'd15);
  endfunction

  assign clr         = (bus.push ^ push_q) | (bus.pop ^ pop_q);
  assign align_clamp = (bus.align > 5'd16) ? 5'd16 : bus.align;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      div_cnt_q  <= '0;
      align_q    <= '0;
      bclk_q     <= 1'b0;
      cnt_q      <= '0;
      tx_q       <= 1'b0;
      tx_sh_l_q  <= '0;
      tx_sh_r_q  <= '0;
      rx_sh_l_q  <= '0;
      rx_sh_r_q  <= '0;
      rx_pcm_l_q <= '0;
      rx_pcm_r_q <= '0;
      full_q     <= 1'b0;
      ovr_q      <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      align_q    <= align_d;
      bclk_q     <= bclk_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      tx_sh_l_q  <= tx_sh_l_d;
      tx_sh_r_q  <= tx_sh_r_d;
      rx_sh_l_q  <= rx_sh_l_d;
      rx_sh_r_q  <= rx_sh_r_d;
      rx_pcm_l_q <= rx_pcm_l_d;
      rx_pcm_r_q <= rx_pcm_r_d;
      full_q     <= full_d;
      ovr_q      <= ovr_d;
      push_q     <= bus.push;
      pop_q      <= bus.pop;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    align_d    = align_q;
    bclk_d     = bclk_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    tx_sh_l_d  = tx_sh_l_q;
    tx_sh_r_d  = tx_sh_r_q;
    rx_sh_l_d  = rx_sh_l_q;
    rx_sh_r_d  = rx_sh_r_q;
    rx_pcm_l_d = rx_pcm_l_q;
    rx_pcm_r_d = rx_pcm_r_q;
    full_d     = full_q;
    ovr_d      = ovr_q;
    slot_step  = 1'b0;
    slot_start = 1'b0;
    win_align  = align_q;

    case (state_q)
      ST_IDLE: begin
        bclk_d = 1'b0;
        cnt_d  = '0;
        tx_d   = 1'b0;
        full_d = 1'b0;
        ovr_d  = 1'b0;
        if (bus.enable) begin
          // Enable rise: slot 0 begins on this edge, but it is not a wrap.
          state_d    = ST_RUN;
          div_d      = bus.div;
          div_cnt_d  = bus.div;
          align_d    = align_clamp;
          win_align  = align_clamp;
          rx_sh_l_d  = '0;
          rx_sh_r_d  = '0;
          slot_step  = 1'b1;
          slot_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
          bclk_d  = 1'b0;
          cnt_d   = '0;
          tx_d    = 1'b0;
          full_d  = 1'b0;
          ovr_d   = 1'b0;
        end else begin
          if (clr) full_d = 1'b0;
          if (div_cnt_q == 8'd0) begin
            div_cnt_d = div_q;
            bclk_d    = ~bclk_q;
            if (bclk_q) begin
              // bclk falling edge: next slot
              cnt_d     = cnt_q + 6'd1;
              slot_step = 1'b1;
              if (cnt_q == 6'd63) begin
                slot_start = 1'b1;
                rx_pcm_l_d = rx_sh_l_q;
                rx_pcm_r_d = rx_sh_r_q;
                // A wrap sets full even against a concurrent clear.
                full_d     = 1'b1;
                if (full_q && !clr) ovr_d = 1'b1;
              end
            end else begin
              // bclk rising edge: sample rx in the current slot
              if (in_win(cnt_q, align_q, 1'b0)) rx_sh_l_d = {rx_sh_l_q[14:0], bus.rx};
              if (in_win(cnt_q, align_q, 1'b1)) rx_sh_r_d = {rx_sh_r_q[14:0], bus.rx};
            end
          end else begin
            div_cnt_d = div_cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared slot advance: tx for the new slot cnt_d, taking fresh PCM
    // words directly when the new slot is slot 0.
    tx_src_l = slot_start ? bus.tx_pcm_l : tx_sh_l_q;
    tx_src_r = slot_start ? bus.tx_pcm_r : tx_sh_r_q;
    if (slot_step) begin
      tx_d      = 1'b0;
      tx_sh_l_d = tx_src_l;
      tx_sh_r_d = tx_src_r;
      if (in_win(cnt_d, win_align, 1'b0)) begin
        tx_d      = tx_src_l[15];
        tx_sh_l_d = {tx_src_l[14:0], 1'b0};
      end else if (in_win(cnt_d, win_align, 1'b1)) begin
        tx_d      = tx_src_r[15];
        tx_sh_r_d = {tx_src_r[14:0], 1'b0};
      end
    end
  end

  assign bus.bclk     = bclk_q;
  assign bus.lrclk    = cnt_q[5];
  assign bus.tx       = tx_q;
  assign bus.rx_pcm_l = rx_pcm_l_q;
  assign bus.rx_pcm_r = rx_pcm_r_q;
  assign bus.full     = full_q;
  assign bus.ovr      = ovr_q;

endmodule

// File: tb/tb_i2s_master.sv
module tb_i2s_master;
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic loop_en = 1'b0;

  i2s_master_if bus();

  i2s_master dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.rx = loop_en & bus.tx;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;

  typedef struct {
    logic [4:0]  align;
    logic [15:0] pcm_l;
    logic [15:0] pcm_r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    int          eff_align;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic exp_tx(input int slot, input int a,
                                  input logic [15:0] l, input logic [15:0] r);
    logic [3:0] idx;
    if (slot >= a && slot < a + 16) begin
      idx = 4'(15 - (slot - a));
      return l[idx];
    end
    if (slot >= 32 + a && slot < 48 + a) begin
      idx = 4'(15 - (slot - 32 - a));
      return r[idx];
    end
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic start_link();
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  task automatic stop_link();
    bus.enable = 1'b0;
    step();
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int berr, lerr, terr, ferr;

    vecs[0] = '{5'd1,  16'hA5C3, 16'h8001, 16'hA5C3, 16'h8001, 1};
    vecs[1] = '{5'd0,  16'h7FFE, 16'h0001, 16'h7FFE, 16'h0001, 0};
    vecs[2] = '{5'd16, 16'h7FFE, 16'h0001, 16'h7FFE, 16'h0001, 16};
    vecs[3] = '{5'd20, 16'h7FFE, 16'h0001, 16'h7FFE, 16'h0001, 16};
    vecs[4] = '{5'd5,  16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC, 5};

    bus.enable   = 1'b0;
    bus.div      = 8'd0;
    bus.align    = 5'd0;
    bus.tx_pcm_l = 16'h0;
    bus.tx_pcm_r = 16'h0;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;

    #2 rstn = 1'b0;
    #2;
    check("rst_bclk",  bus.bclk, 0);
    check("rst_lrclk", bus.lrclk, 0);
    check("rst_tx",    bus.tx, 0);
    check("rst_rx_l",  bus.rx_pcm_l, 0);
    check("rst_rx_r",  bus.rx_pcm_r, 0);
    check("rst_full",  bus.full, 0);
    check("rst_ovr",   bus.ovr, 0);
    #23 rstn = 1'b1;
    step();

    // Clocking at div=3; div changes while running must be ignored.
    bus.div = 8'd3;
    bus.align = 5'd1;
    start_link();
    berr = 0;
    lerr = 0;
    for (int k = 0; k <= 1100; k++) begin
      if (bus.bclk !== 1'((cyc / 4) % 2)) berr++;
      if (bus.lrclk !== 1'((cyc / 256) % 2)) lerr++;
      if (k == 100) bus.div = 8'd0;
      if (k < 1100) step();
    end
    check("bclk_wave_errs", berr, 0);
    check("lrclk_wave_errs", lerr, 0);
    stop_link();

    // Loopback table
    bus.div = 8'd0;
    loop_en = 1'b1;
    foreach (vecs[i]) begin
      stop_link();
      bus.align    = vecs[i].align;
      bus.tx_pcm_l = vecs[i].pcm_l;
      bus.tx_pcm_r = vecs[i].pcm_r;
      start_link();
      terr = 0;
      for (int k = 0; k <= 256; k++) begin
        if (bus.tx !== exp_tx((cyc / 2) % 64, vecs[i].eff_align, vecs[i].pcm_l, vecs[i].pcm_r))
          terr++;
        if (cyc == 127) check("lb_full_pre_wrap", bus.full, 0);
        if (cyc == 128) check("lb_full_wrap1", bus.full, 1);
        if (k < 256) step();
      end
      check("lb_tx_bits", terr, 0);
      check("lb_rx_l", bus.rx_pcm_l, vecs[i].exp_l);
      check("lb_rx_r", bus.rx_pcm_r, vecs[i].exp_r);
      check("lb_full_wrap2", bus.full, 1);
      check("lb_ovr_wrap2", bus.ovr, 1);
    end

    // Handshake: pop toggle clears, missing acks overrun
    stop_link();
    bus.align = 5'd0;
    bus.tx_pcm_l = 16'h7FFE;
    bus.tx_pcm_r = 16'h0001;
    start_link();
    run_to(128);
    check("hs_full_set", bus.full, 1);
    run_to(131);
    bus.pop = ~bus.pop;
    step();
    check("hs_full_cleared", bus.full, 0);
    check("hs_ovr_clean", bus.ovr, 0);
    run_to(256);
    check("hs_full_wrap2", bus.full, 1);
    check("hs_ovr_wrap2", bus.ovr, 0);
    run_to(384);
    check("hs_ovr_set", bus.ovr, 1);
    run_to(400);
    check("hs_ovr_sticky", bus.ovr, 1);
    bus.enable = 1'b0;
    step();
    check("hs_ovr_disable", bus.ovr, 0);
    check("hs_full_disable", bus.full, 0);

    // Clear coinciding with a wrap
    step();
    start_link();
    run_to(128);
    check("cw_full_wrap1", bus.full, 1);
    run_to(255);
    bus.push = ~bus.push;
    step();
    check("cw_full_kept", bus.full, 1);
    check("cw_ovr_kept", bus.ovr, 0);
    run_to(384);
    check("cw_ovr_later", bus.ovr, 1);

    // Abort at slot 40, then restart
    stop_link();
    bus.align = 5'd1;
    bus.tx_pcm_l = 16'hA5C3;
    bus.tx_pcm_r = 16'h8001;
    start_link();
    step();
    bus.tx_pcm_l = 16'h1111;
    bus.tx_pcm_r = 16'h0100;
    run_to(209);
    check("ab_pre_tx", bus.tx, 1);
    check("ab_pre_bclk", bus.bclk, 1);
    check("ab_pre_lrclk", bus.lrclk, 1);
    check("ab_pre_full", bus.full, 1);
    bus.enable = 1'b0;
    step();
    check("ab_bclk", bus.bclk, 0);
    check("ab_lrclk", bus.lrclk, 0);
    check("ab_tx", bus.tx, 0);
    check("ab_full", bus.full, 0);
    check("ab_rx_l", bus.rx_pcm_l, 16'hA5C3);
    check("ab_rx_r", bus.rx_pcm_r, 16'h8001);
    step();
    start_link();
    check("re_bclk0", bus.bclk, 0);
    check("re_lrclk0", bus.lrclk, 0);
    ferr = 0;
    for (int k = 0; k < 128; k++) begin
      if (bus.full !== 1'b0) ferr++;
      step();
    end
    check("re_full_quiet", ferr, 0);
    check("re_full_wrap", bus.full, 1);
    check("re_rx_l", bus.rx_pcm_l, 16'h1111);
    check("re_rx_r", bus.rx_pcm_r, 16'h0100);

    // Async reset mid-frame, then restart straight out of reset
    run_to(337);
    check("ar_pre_tx", bus.tx, 1);
    check("ar_pre_ovr", bus.ovr, 1);
    #2 rstn = 1'b0;
    #1;
    check("ar_bclk", bus.bclk, 0);
    check("ar_lrclk", bus.lrclk, 0);
    check("ar_tx", bus.tx, 0);
    check("ar_rx_l", bus.rx_pcm_l, 0);
    check("ar_rx_r", bus.rx_pcm_r, 0);
    check("ar_full", bus.full, 0);
    check("ar_ovr", bus.ovr, 0);
    bus.tx_pcm_l = 16'hA5C3;
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    check("rs_bclk0", bus.bclk, 0);
    check("rs_tx_slot0", bus.tx, 0);
    run_to(2);
    check("rs_tx_slot1", bus.tx, 1);
    run_to(127);
    check("rs_full_pre", bus.full, 0);
    run_to(128);
    check("rs_full_wrap", bus.full, 1);
    check("rs_rx_l", bus.rx_pcm_l, 16'hA5C3);
    check("rs_rx_r", bus.rx_pcm_r, 16'h0100);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/i2s_master.md
I2S_MASTER -- requirements
Module: i2s_master

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  1 = run the link; 0 = idle and clear.
- div  in  8  bclk half-period = div+1 clk cycles.
- align  in  5  slot index of the data MSB within each channel half; captured at enable rise.
- bclk  out  1  bit clock.
- lrclk  out  1  word select (0 = left, 1 = right).
- tx  out  1  serial data out, changes on bclk falling edge.
- rx  in  1  serial data in, sampled on bclk rising edge.
- tx_pcm_l, tx_pcm_r  in  16  signed PCM words to send.
- rx_pcm_l, rx_pcm_r  out  16  signed PCM words received.
- full  out  1  a received frame is ready and tx words have been taken.
- push, pop  in  1  toggle handshakes; any level change acknowledges full.
- ovr  out  1  sticky overrun.

Function
REQ-002 SHALL capture div and align when enable rises; changes to either while enable=1 SHALL be ignored.
REQ-003 SHALL clamp a captured align value >16 to 16.
REQ-004 SHALL toggle bclk every div+1 clk cycles while enabled; bclk SHALL be 0 for the first half-period after enable rises.
REQ-005 SHALL keep a 6-bit slot counter cnt (0..63), incremented on each bclk falling edge, wrapping 63->0; cnt=0 during the first bclk period after enable.
REQ-006 SHALL drive lrclk = cnt[5], so lrclk changes only on a bclk falling edge, with 32 bclk per channel and 64 per frame.
REQ-007 SHALL sample tx_pcm_l and tx_pcm_r into shift registers at every cnt=0 slot start, including the first slot after enable.
REQ-008 SHALL send tx MSB-first: the left word in slots align..align+15, the right word in slots 32+align..47+align; tx SHALL be 0 in all other slots.
REQ-009 SHALL update tx as a register on the clk edge that produces the bclk falling edge (for the very first slot: the clk edge at which enable is seen high).
REQ-010 SHALL shift rx in MSB-first on the clk edge that produces a bclk rising edge, in the same slot windows as REQ-008.
REQ-011 On each 63->0 wrap SHALL copy the assembled left/right words to rx_pcm_l/rx_pcm_r and set full=1 in the same cycle; the first cnt=0 after enable is not a wrap and SHALL NOT set full.
REQ-012 SHALL register push and pop each cycle; a level change on either SHALL clear full on the next clk edge.
REQ-013 On a wrap with full=1 and no concurrent clear SHALL set ovr=1; a wrap coinciding with a clear SHALL leave full=1 with ovr unchanged (the set wins).
REQ-014 While enable=0 SHALL hold bclk=0, lrclk=0, tx=0, cnt=0, full=0, ovr=0; rx_pcm_l and rx_pcm_r SHALL retain their values.
REQ-015 Dropping enable mid-frame SHALL force the REQ-014 state on the next clk edge, with no partial word transferred to rx_pcm.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 rstn=0 SHALL asynchronously force bclk=0, lrclk=0, tx=0, rx_pcm_l=0, rx_pcm_r=0, full=0, ovr=0, cnt=0, and clear all shift and capture registers.
REQ-018 Deasserting rstn with enable=1 SHALL start at slot 0 exactly as an enable rise does.

Verification
REQ-019 Reset: rstn=0 mid-frame with enable=1 -> all outputs 0 immediately, without waiting for a clk edge.
REQ-020 Clocking: div=3, enable=1 -> bclk period 8 clk; lrclk period 512 clk; each lrclk edge coincides with a bclk falling edge.
REQ-021 Loopback: tx tied to rx, align=1, tx_pcm_l=16'hA5C3, tx_pcm_r=16'h8001 -> at the second wrap, rx_pcm_l=16'hA5C3, rx_pcm_r=16'h8001, full=1; tx=1 in slot 1, tx=0 in slot 0 and slots 17..31.
REQ-022 Alignment: loopback with align=0, then 16, then 20, using 16'h7FFE/16'h0001 -> received words match in every case; align=20 produces bit timing identical to align=16.
REQ-023 Handshake: toggle pop 3 cycles after full -> full=0 on the next cycle; no toggle across two wraps -> ovr=1 until enable=0; clear in the same cycle as a wrap -> full=1, ovr=0.
REQ-024 Abort: enable=0 at slot 40 -> bclk, lrclk, tx, full all 0 one cycle later and rx_pcm unchanged; re-enable -> restart at slot 0 with no full until the first wrap.
